// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the reg_map write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {SRC_NONE, SRC_I2C, SRC_HDL, SRC_PRE} wr_src_e;

  localparam int unsigned DefAddrW     = 8;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefFifoDepth = 4;

endpackage

// File: rtl/reg_arb_fifo.sv
// Synchronous FIFO buffering I2C writes; accepts push and pop together even when full.
module reg_arb_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/reg_map_write_arbiter.sv
// Merges buffered I2C writes with round-robin handler/preload writes into one registered port.
module reg_map_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned I2C_FIFO_DEPTH = DefFifoDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_wr_valid,
  input  logic [ADDR_W-1:0] i2c_wr_addr,
  input  logic [DATA_W-1:0] i2c_wr_data,
  input  logic              hdl_req,
  input  logic [ADDR_W-1:0] hdl_addr,
  input  logic [DATA_W-1:0] hdl_wdata,
  output logic              hdl_gnt,
  input  logic              pre_req,
  input  logic [ADDR_W-1:0] pre_addr,
  input  logic [DATA_W-1:0] pre_data,
  output logic              pre_gnt,
  input  logic              wr_freeze,
  input  logic              ovf_clr,
  output logic              rm_wr_en,
  output logic [ADDR_W-1:0] rm_addr,
  output logic [DATA_W-1:0] rm_wdata,
  output logic              i2c_ovf,
  output logic              busy
);

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic                     ovf_set;
  wr_src_e                  winner;
  wr_src_e                  rr_last_q;
  logic                     rm_wr_en_q;
  logic [ADDR_W-1:0]        rm_addr_q;
  logic [DATA_W-1:0]        rm_wdata_q;
  logic                     i2c_ovf_q;

  reg_arb_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (I2C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({i2c_wr_addr, i2c_wr_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Queued I2C writes always win; handler/preload alternate only on contention.
  always_comb begin
    winner  = SRC_NONE;
    hdl_gnt = 1'b0;
    pre_gnt = 1'b0;
    if (!wr_freeze) begin
      if (!fifo_empty) begin
        winner = SRC_I2C;
      end else if (hdl_req && (!pre_req || rr_last_q == SRC_PRE)) begin
        winner  = SRC_HDL;
        hdl_gnt = 1'b1;
      end else if (pre_req) begin
        winner  = SRC_PRE;
        pre_gnt = 1'b1;
      end
    end
  end

  assign fifo_pop  = (winner == SRC_I2C);
  assign fifo_push = i2c_wr_valid && (!fifo_full || fifo_pop);
  assign ovf_set   = i2c_wr_valid && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rm_wr_en_q <= 1'b0;
      rm_addr_q  <= '0;
      rm_wdata_q <= '0;
      rr_last_q  <= SRC_PRE;
      i2c_ovf_q  <= 1'b0;
    end else begin
      rm_wr_en_q <= (winner != SRC_NONE);
      unique case (winner)
        SRC_I2C: {rm_addr_q, rm_wdata_q} <= fifo_head;
        SRC_HDL: begin
          rm_addr_q  <= hdl_addr;
          rm_wdata_q <= hdl_wdata;
          rr_last_q  <= SRC_HDL;
        end
        SRC_PRE: begin
          rm_addr_q  <= pre_addr;
          rm_wdata_q <= pre_data;
          rr_last_q  <= SRC_PRE;
        end
        default: ;
      endcase
      if (ovf_set)      i2c_ovf_q <= 1'b1;
      else if (ovf_clr) i2c_ovf_q <= 1'b0;
    end
  end

  assign rm_wr_en = rm_wr_en_q;
  assign rm_addr  = rm_addr_q;
  assign rm_wdata = rm_wdata_q;
  assign i2c_ovf  = i2c_ovf_q;
  assign busy     = !fifo_empty || rm_wr_en_q;

endmodule

// File: doc/reg_map_write_arbiter.md
# reg_map_write_arbiter

Single-port write arbiter in front of the shared `reg_map`. It merges three independent write sources into one registered write port:
- I2C slave core writes (already synchronized to `clk`);
- CDC command handler writes;
- FPGA-internal preload writes.

I2C writes are buffered so they are never lost. Handler and preload share the remaining bandwidth round-robin. A freeze input blocks all writes so the handler can snapshot registers coherently.

## Interface
Parameters:
- `ADDR_W`, default 8: register address width.
- `DATA_W`, default 8: register data width.
- `I2C_FIFO_DEPTH`, default 4: I2C write buffer entries; power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `i2c_wr_valid`  in  1  single-cycle write pulse from synchronized I2C core.
- `i2c_wr_addr`  in  ADDR_W  address qualified by `i2c_wr_valid`.
- `i2c_wr_data`  in  DATA_W  data qualified by `i2c_wr_valid`.
- `hdl_req`  in  1  handler write request; held with addr/data until granted.
- `hdl_addr`  in  ADDR_W  handler address.
- `hdl_wdata`  in  DATA_W  handler data.
- `hdl_gnt`  out  1  combinational accept; transfer when `hdl_req && hdl_gnt`.
- `pre_req`  in  1  preload write request; same rules as handler.
- `pre_addr`  in  ADDR_W  preload address.
- `pre_data`  in  DATA_W  preload data.
- `pre_gnt`  out  1  combinational accept for preload.
- `wr_freeze`  in  1  while high, no write issued and no grant given.
- `ovf_clr`  in  1  clears `i2c_ovf`.
- `rm_wr_en`  out  1  registered write strobe to `reg_map`.
- `rm_addr`  out  ADDR_W  registered write address.
- `rm_wdata`  out  DATA_W  registered write data.
- `i2c_ovf`  out  1  sticky flag: an I2C write was dropped.
- `busy`  out  1  high when the FIFO is non-empty or `rm_wr_en` is high.

## Operation
- Each cycle, at most one source is selected (the winner). Priority when `wr_freeze` is low:
  1. I2C FIFO head, when the FIFO is non-empty.
  2. Otherwise handler vs preload, round-robin. `rr_last` records the last granted of the two; on contention the other one wins. A lone requester always wins.
- Selection is from registered FIFO state. An I2C push in cycle N is poppable in N+1 at the earliest.
- The winner's addr/data load `rm_addr`/`rm_wdata`, and `rm_wr_en`=1, in the next cycle. `rm_wr_en` is 0 in any cycle after one with no winner. `rm_addr`/`rm_wdata` hold their last value when idle.
- `hdl_gnt`/`pre_gnt` are 0 whenever the FIFO is non-empty or `wr_freeze`=1. At most one grant is high per cycle.
- FIFO push: `i2c_wr_valid` and the FIFO is not full, or the FIFO is full and pops in the same cycle.
  - Push on full without a pop: the write is dropped and `i2c_ovf` is set.
  - Set has priority over `ovf_clr` in the same cycle.
- Freeze: the FIFO keeps accepting pushes. No pop and no grant occur. The pending `rm_wr_en` from the previous cycle still completes.
- Reset: FIFO empty, `rm_wr_en`=0, `rm_addr`=0, `rm_wdata`=0, `i2c_ovf`=0, `rr_last`=PRE (handler wins the first contention), `busy`=0. Reset mid-burst discards queued I2C writes. Requesters must re-request.

## Timing
- Latency, request to `rm_wr_en`:
  - handler/preload, uncontended: 1 cycle (grant cycle N, strobe N+1);
  - I2C, empty FIFO: 2 cycles (pulse N, pop N+1, strobe N+2).
- Throughput: one write per cycle sustained.
- Worst-case handler wait: FIFO drain time plus 1 preload grant.
- FIFO count width is `$clog2(I2C_FIFO_DEPTH)+1`. Pointers wrap modulo depth.

## Structure
- Package `reg_arb_pkg`:
  - `typedef enum logic [1:0] {SRC_NONE, SRC_I2C, SRC_HDL, SRC_PRE} wr_src_e`;
  - default width localparams.
- Sub-module `reg_arb_fifo`: synchronous FIFO with push/pop/full/empty, same-cycle push+pop on full, `{addr,data}` payload.
- Top: winner select, `rr_last` register, output register, overflow flag.

## Test plan
1. Only `hdl_req` with addr 0x02, data 0xA5 → `hdl_gnt`=1 at cycle N; `rm_wr_en`=1, `rm_addr`=0x02, `rm_wdata`=0xA5 at N+1; `rm_wr_en`=0 at N+2 once `hdl_req` drops.
2. `hdl_req` and `pre_req` held high for 4 cycles after reset → grant order HDL, PRE, HDL, PRE; 4 consecutive `rm_wr_en` pulses.
3. I2C pulse (0x01, 0x11) in the same cycle as `hdl_req` → handler granted first. Next cycle the I2C write pops, `hdl_gnt`=0 while the FIFO is non-empty. Strobes: handler write, then I2C 0x01/0x11.
4. `wr_freeze`=1 with 5 I2C pulses (0x00–0x04), depth 4 → `rm_wr_en` stays 0, fifth write dropped, `i2c_ovf`=1. Release freeze → exactly 4 writes 0x00–0x03 in order. `ovf_clr` → `i2c_ovf`=0.
5. FIFO full, freeze low, new I2C pulse in a pop cycle → no drop, `i2c_ovf` stays 0, all writes emitted in order.
6. Assert `rst` with 3 queued I2C writes → next cycle `rm_wr_en`=0, `busy`=0, no queued write emitted afterward.
